// File: rtl/seq_mon_pkg.sv
// Shared FSM encoding, default widths and saturation limits for seq_pattern_monitor.
package seq_mon_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } mon_state_e;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned CW_DEF = 16;
  localparam int unsigned PW_DEF = 10;

  localparam logic [CW_DEF-1:0] CNT_MAX = '1;
  localparam logic [PW_DEF-1:0] PER_MAX = '1;

endpackage

// File: rtl/seq_pattern_monitor_sat_counter.sv
// Saturating up-counter with clear, load-to-one and a sticky flag that records
// an increment attempted while already at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load1,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_sat
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;
  logic         r_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_load1) begin
      r_count <= ONE;
    end else if (i_inc) begin
      if (r_count == MAX) r_sat <= 1'b1;
      else                r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;
  assign o_sat   = r_sat;

endmodule

// File: rtl/seq_pattern_monitor.sv
// Pattern detector / match counter / match-period meter on the generator sequence.
// Define SEQ_MON_MINMAX_EN to add period_min / period_max tracking outputs.
module seq_pattern_monitor
  import seq_mon_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] q_in,
  input  logic          q_valid,
  input  logic [DW-1:0] target,
  input  logic          arm,
  output logic          match,
  output logic [CW-1:0] match_count,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          period_ovf,
  output logic          busy
`ifdef SEQ_MON_MINMAX_EN
  ,
  output logic [PW-1:0] period_min,
  output logic [PW-1:0] period_max
`endif
);

  mon_state_e    r_state, w_state_nxt;
  logic [DW-1:0] r_target;
  logic          r_match;
  logic [PW-1:0] r_period;
  logic          r_period_valid;
  logic [PW-1:0] w_per_cnt;
  logic          w_per_sat;
  logic          w_cnt_sat;
  logic          w_hit;
  logic          w_first;
  logic          w_next;

  assign w_hit = q_valid && (q_in == r_target);

  // arm outranks a coincident match in every state
  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_next      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (arm) w_state_nxt = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (arm) begin
          w_state_nxt = WAIT_FIRST;
        end else if (w_hit) begin
          w_first     = 1'b1;
          w_state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (arm)        w_state_nxt = WAIT_FIRST;
        else if (w_hit) w_next      = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  sat_counter #(.W(PW)) u_period_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (arm),
    .i_load1 (w_first || w_next),
    .i_inc   (r_state == MEASURE),
    .o_count (w_per_cnt),
    .o_sat   (w_per_sat)
  );

  sat_counter #(.W(CW)) u_match_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (arm),
    .i_load1 (1'b0),
    .i_inc   ((w_first || w_next) && !w_cnt_sat),
    .o_count (match_count),
    .o_sat   (w_cnt_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_target       <= '0;
      r_match        <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_match <= w_first || w_next;
      if (arm) begin
        r_target       <= target;
        r_period       <= '0;
        r_period_valid <= 1'b0;
      end else if (w_next) begin
        r_period       <= w_per_cnt;
        r_period_valid <= 1'b1;
      end
    end
  end

`ifdef SEQ_MON_MINMAX_EN
  logic [PW-1:0] r_min;
  logic [PW-1:0] r_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min <= '1;
      r_max <= '0;
    end else if (arm) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_next) begin
      if (w_per_cnt < r_min) r_min <= w_per_cnt;
      if (w_per_cnt > r_max) r_max <= w_per_cnt;
    end
  end

  assign period_min = r_min;
  assign period_max = r_max;
`endif

  assign match        = r_match;
  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign period_ovf   = w_per_sat;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_seq_pattern_monitor.sv
// Directed bench for seq_pattern_monitor: gap-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_seq_pattern_monitor;

  localparam int DW   = 8;
  localparam int CW   = 6;
  localparam int PW   = 10;
  localparam int CMAX = (1 << CW) - 1;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] q_in;
  logic          q_valid;
  logic [DW-1:0] target;
  logic          arm;
  logic          match;
  logic [CW-1:0] match_count;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          period_ovf;
  logic          busy;
`ifdef SEQ_MON_MINMAX_EN
  logic [PW-1:0] period_min;
  logic [PW-1:0] period_max;
`endif

  seq_pattern_monitor #(.DW(DW), .CW(CW), .PW(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .q_in         (q_in),
    .q_valid      (q_valid),
    .target       (target),
    .arm          (arm),
    .match        (match),
    .match_count  (match_count),
    .period       (period),
    .period_valid (period_valid),
    .period_ovf   (period_ovf),
    .busy         (busy)
`ifdef SEQ_MON_MINMAX_EN
    ,
    .period_min   (period_min),
    .period_max   (period_max)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: works from absolute cycle numbers of matches.
  int cyc = 0;
  bit m_armed, m_have_first, m_match, m_pv, m_ovf;
  int m_last, m_cnt, m_period, m_min, m_max;
  logic [DW-1:0] m_tgt;

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_have_first = 0; m_match = 0; m_pv = 0; m_ovf = 0;
    m_last = 0; m_cnt = 0; m_period = 0; m_min = PMAX; m_max = 0; m_tgt = '0;
  endtask

  task automatic model_step();
    int gap;
    cyc++;
    if (rst) begin
      model_reset();
    end else if (arm) begin
      model_reset();
      m_armed = 1;
      m_tgt   = target;
    end else if (m_armed) begin
      if (q_valid && q_in == m_tgt) begin
        m_match = 1;
        m_cnt   = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (m_have_first) begin
          gap      = cyc - m_last;
          m_period = (gap > PMAX) ? PMAX : gap;
          m_pv     = 1;
          if (m_period < m_min) m_min = m_period;
          if (m_period > m_max) m_max = m_period;
        end
        m_have_first = 1;
        m_last       = cyc;
      end else begin
        m_match = 0;
        if (m_have_first && (cyc - m_last) >= PMAX) m_ovf = 1;
      end
    end else begin
      m_match = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      pin("match",        32'(match),        32'(m_match));
      pin("match_count",  32'(match_count),  32'(m_cnt));
      pin("period",       32'(period),       32'(m_period));
      pin("period_valid", 32'(period_valid), 32'(m_pv));
      pin("period_ovf",   32'(period_ovf),   32'(m_ovf));
      pin("busy",         32'(busy),         32'(m_armed));
`ifdef SEQ_MON_MINMAX_EN
      pin("period_min",   32'(period_min),   32'(m_min));
      pin("period_max",   32'(period_max),   32'(m_max));
`endif
    end
  end

  task automatic tick(input logic a, input logic v, input logic [DW-1:0] q,
                      input logic [DW-1:0] t);
    arm = a; q_valid = v; q_in = q; target = t;
    @(posedge clk); #1;
    model_step();
    arm = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; q_valid = 1'b0; q_in = '0; target = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pin("rst_busy",  32'(busy), 0);
    pin("rst_count", 32'(match_count), 0);
    pin("rst_pv",    32'(period_valid), 0);
    rst = 1'b0;

    // Pattern present without arm is ignored
    repeat (4) tick(1'b0, 1'b1, 8'h55, 8'h55);
    pin("noarm_match", 32'(match), 0);
    pin("noarm_busy",  32'(busy), 0);

    // Target 01 recurring every 8 valid cycles
    tick(1'b1, 1'b1, 8'h00, 8'h01);
    for (int i = 0; i <= 9; i++) begin
      tick(1'b0, 1'b1, 8'(i % 8), 8'h01);
      if (i == 1) begin
        pin("first_count", 32'(match_count), 1);
        pin("first_pv",    32'(period_valid), 0);
        pin("first_match", 32'(match), 1);
      end
    end
    pin("second_period", 32'(period), 8);
    pin("second_pv",     32'(period_valid), 1);
    pin("second_count",  32'(match_count), 2);

    // Arm coincident with a match: arm wins
    tick(1'b1, 1'b1, 8'h01, 8'h01);
    pin("armhit_count", 32'(match_count), 0);
    pin("armhit_match", 32'(match), 0);
    pin("armhit_busy",  32'(busy), 1);
    tick(1'b0, 1'b1, 8'h00, 8'h01);
    tick(1'b0, 1'b1, 8'h01, 8'h01);
    pin("armhit_next_count", 32'(match_count), 1);

    // Invalid cycles still count toward the period
    for (int i = 2; i <= 4; i++) tick(1'b0, 1'b1, 8'(i), 8'h01);
    repeat (3) tick(1'b0, 1'b0, 8'h01, 8'h01);
    tick(1'b0, 1'b1, 8'h01, 8'h01);
    pin("gap_period", 32'(period), 7);

    // Period counter overflow
    repeat (1100) tick(1'b0, 1'b1, 8'h05, 8'h01);
    pin("ovf_flag",   32'(period_ovf), 1);
    pin("ovf_period", 32'(period), 7);
    tick(1'b0, 1'b1, 8'h01, 8'h01);
    pin("ovf_load",   32'(period), PMAX);
    pin("ovf_pv",     32'(period_valid), 1);

    // Match counter saturation; match keeps pulsing
    repeat (70) tick(1'b0, 1'b1, 8'h01, 8'h01);
    pin("sat_count",  32'(match_count), CMAX);
    pin("sat_match",  32'(match), 1);
    pin("sat_period", 32'(period), 1);

    // Gaps 5, 9, 3 after a fresh arm
    tick(1'b1, 1'b0, 8'h00, 8'h2A);
    tick(1'b0, 1'b1, 8'h2A, 8'h2A);
    repeat (4) tick(1'b0, 1'b1, 8'h00, 8'h2A);
    tick(1'b0, 1'b1, 8'h2A, 8'h2A);
    pin("gap5", 32'(period), 5);
    repeat (8) tick(1'b0, 1'b1, 8'h00, 8'h2A);
    tick(1'b0, 1'b1, 8'h2A, 8'h2A);
    repeat (2) tick(1'b0, 1'b1, 8'h00, 8'h2A);
    tick(1'b0, 1'b1, 8'h2A, 8'h2A);
    pin("gap3", 32'(period), 3);
    pin("mm_count", 32'(match_count), 4);
    pin("mm_ovf", 32'(period_ovf), 0);
`ifdef SEQ_MON_MINMAX_EN
    pin("min_lit", 32'(period_min), 3);
    pin("max_lit", 32'(period_max), 9);
`endif

    // Asynchronous reset mid-run
    tick(1'b0, 1'b1, 8'h00, 8'h2A);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    pin("arst_busy",  32'(busy), 0);
    pin("arst_count", 32'(match_count), 0);
    pin("arst_period", 32'(period), 0);
    pin("arst_pv",    32'(period_valid), 0);
`ifdef SEQ_MON_MINMAX_EN
    pin("arst_min",   32'(period_min), PMAX);
`endif
    @(posedge clk); #1;
    model_step();
    rst = 1'b0;
    repeat (3) tick(1'b0, 1'b1, 8'h2A, 8'h2A);
    pin("post_rst_match", 32'(match), 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_monitor.md
Name: seq_pattern_monitor

Overview:
- Downstream consumer of the 8-bit free-running sequence generator output (q[7:0]).
- Samples the sequence every valid cycle, detects a programmable target pattern, counts matches, and measures the period between consecutive matches in clock cycles.
- Results feed the lab board display and LED logic.
- Purely synchronous to the generator clock.

Parameters:
- DW, 8, width of the sampled sequence word
- CW, 16, width of the match counter
- PW, 10, width of the period counter (max measurable period 2^PW-1 cycles)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- q_in  input  DW  sequence word from the generator
- q_valid  input  1  q_in is valid this cycle; the monitor ignores cycles with q_valid=0
- target  input  DW  pattern to detect; sampled only on the arm cycle
- arm  input  1  single-cycle pulse: latch target, clear statistics, start monitoring
- match  output  1  one-cycle pulse, registered, on a detected match
- match_count  output  CW  number of matches since arm, saturating
- period  output  PW  cycles between the last two matches
- period_valid  output  1  high once at least two matches have been seen since arm
- period_ovf  output  1  sticky: period counter saturated before a match arrived
- busy  output  1  high when not in IDLE

Behaviour:
- Reset is asynchronous and active-high. All outputs are 0, target register is 0, FSM is IDLE.
- The FSM has three states: IDLE, WAIT_FIRST, MEASURE.
- IDLE:
  - Matches are ignored.
  - arm=1 moves to WAIT_FIRST. The same edge latches target, clears match_count, period, period_valid and period_ovf.
- WAIT_FIRST:
  - On q_valid && q_in==target_reg: match=1 the next cycle, match_count+1, period counter loaded with 1, go to MEASURE.
- MEASURE:
  - The period counter increments on every clock edge, valid or not. It saturates at all-ones and sets period_ovf.
  - On a match: period <= counter value, period_valid <= 1, counter reloads to 1, match pulses, match_count increments.
- Period counts clock cycles between the two matching samples. Example: matches at q_valid edges n and n+5 give period=5.
- Latency: match, match_count, period and period_valid update on the clock edge that samples the matching q_in. They are visible one cycle after q_in is presented.
- match_count saturates at 2^CW-1. match still pulses after saturation.
- If arm and a match occur in the same cycle, arm wins. Statistics clear, the match is not counted, and the state becomes WAIT_FIRST.
- arm in WAIT_FIRST or MEASURE restarts: same as from IDLE.
- When period_ovf=1 the period output holds its previous value. The next match after overflow still loads the saturated count and sets period_valid.
- busy is high in WAIT_FIRST and MEASURE.
- There is no return to IDLE other than reset.
- If rst asserts mid-measurement, everything returns to reset values immediately. Generator and monitor may leave reset in either order; matches before arm are ignored.

Optional Feature:
- Macro: SEQ_MON_MINMAX_EN.
- Defined:
  - Adds outputs period_min [PW] and period_max [PW].
  - Both update on each period load after the first period sample.
  - On arm/reset: min = all-ones, max = 0.
- Undefined: the ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package seq_mon_pkg holds:
  - the FSM state enum (IDLE=2'd0, WAIT_FIRST=2'd1, MEASURE=2'd2);
  - default DW, CW and PW localparams;
  - the saturation max constants.
- One natural sub-module, sat_counter: parameterised width, with load-1, increment, clear, and a sticky saturated flag. It is used for both the period and match counters.

Test Plan:
- Reset: rst=1 for 20 ns with clk toggling → every output 0, busy=0. q_in==target with no arm → match stays 0.
- Arm target=8'h01 with a stimulus sequence hitting 8'h01 every 8 valid cycles → first match gives match_count=1 and period_valid=0. Second match gives period=8, period_valid=1, match_count=2.
- Same-cycle arm and match (q_in==target on the arm edge) → match_count=0, state WAIT_FIRST. The next match gives count=1.
- q_valid low for 3 cycles between two matches that are otherwise 4 valid cycles apart → period=7 (clock cycles counted), not 4.
- Target never reappears for more than 1023 cycles after the first match → period_ovf=1 and period unchanged. A later match gives period=1023.
- With SEQ_MON_MINMAX_EN defined, matches at gaps 5, 9, 3 → period_min=3, period_max=9. Asserting rst mid-run → all outputs return to 0 asynchronously, before the next clk edge.
